// File: rtl/bellek_denetleyici_pkg.sv
// ============================================================================
// Package : bellek_paket
// Shared widths, default RAM window base, controller state encoding and the
// address range/alignment check used by bellek_denetleyici.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bellek_paket;

  localparam int VERI_BIT  = 32;
  localparam int ADRES_BIT = 32;
  localparam int MASKE_BIT = 4;

  localparam logic [ADRES_BIT-1:0] BELLEK_ADRES_VARSAYILAN = 32'h8000_0000;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

  // Out-of-window or misaligned access. The upper bound is formed in 33 bits
  // so that a window ending exactly at 2^32 does not wrap to zero.
  function automatic logic adres_hatali(input logic [ADRES_BIT-1:0] adres,
                                        input logic [ADRES_BIT-1:0] taban,
                                        input int                   kelime);
    logic [ADRES_BIT:0] ust;
    ust = {1'b0, taban} + (33'(kelime) << 2);
    return (adres < taban) || ({1'b0, adres} >= ust) || (adres[1:0] != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bellek_denetleyici_if.sv
// ============================================================================
// Interface : bellek_if
// Request/response handshake bundle between the core memory port (master)
// and the memory controller (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bellek_if;
  import bellek_paket::*;

  logic                 istek_gecerli;
  logic                 istek_hazir;
  logic [ADRES_BIT-1:0] istek_adres;
  logic                 istek_yaz;
  logic [VERI_BIT-1:0]  istek_yaz_veri;
  logic [MASKE_BIT-1:0] istek_maske;
  logic                 yanit_gecerli;
  logic                 yanit_hazir;
  logic [VERI_BIT-1:0]  yanit_veri;
  logic                 yanit_hata;

  modport master (
    output istek_gecerli, istek_adres, istek_yaz, istek_yaz_veri, istek_maske,
    input  istek_hazir,
    input  yanit_gecerli, yanit_veri, yanit_hata,
    output yanit_hazir
  );

  modport slave (
    input  istek_gecerli, istek_adres, istek_yaz, istek_yaz_veri, istek_maske,
    output istek_hazir,
    output yanit_gecerli, yanit_veri, yanit_hata,
    input  yanit_hazir
  );

endinterface

`default_nettype wire

// File: rtl/bellek_denetleyici_dizisi.sv
// ============================================================================
// Module  : bellek_dizisi
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Contents are never cleared.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bellek_dizisi
  import bellek_paket::*;
#(
  parameter int KELIME  = 1024,
  parameter int IDX_BIT = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 yaz,
  input  logic [MASKE_BIT-1:0] maske,
  input  logic [IDX_BIT-1:0]   idx,
  input  logic [VERI_BIT-1:0]  veri,
  output logic [VERI_BIT-1:0]  q
);

  logic [VERI_BIT-1:0] dizi [KELIME];

  // One access per enable: byte-masked write, or registered read into q.
  always_ff @(posedge clk) begin
    if (en) begin
      if (yaz) begin
        for (int b = 0; b < MASKE_BIT; b++) begin
          if (maske[b]) dizi[idx][8*b +: 8] <= veri[8*b +: 8];
        end
      end else begin
        q <= dizi[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bellek_denetleyici.sv
// ============================================================================
// Module  : bellek_denetleyici
// Main-memory controller: one request at a time, BEKLEME wait states, range
// and alignment checking, registered read data on a valid/ready response.
// Optional macro BELLEK_BAYT_MASKE_EN enables per-byte write strobes;
// without it every write updates the full word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bellek_denetleyici
  import bellek_paket::*;
#(
  parameter logic [ADRES_BIT-1:0] BELLEK_ADRES  = BELLEK_ADRES_VARSAYILAN,
  parameter int                   BELLEK_KELIME = 1024,
  parameter int                   BEKLEME       = 2
) (
  input  logic   clk,
  input  logic   rst,
  bellek_if.slave bus
);

  localparam int         IDX_BIT = $clog2(BELLEK_KELIME);
  localparam logic [3:0] YUKLE   = (BEKLEME > 0) ? 4'(BEKLEME - 1) : 4'd0;

  durum_t               durum, sonraki;
  logic [3:0]           sayac;
  logic                 ram_en;
  logic                 hazir, kabul, gelen_hata;
  logic [ADRES_BIT-1:0] fark;
  logic [IDX_BIT-1:0]   gelen_idx, tut_idx, ram_idx;
  logic                 tut_yaz, tut_hata, ram_yaz;
  logic [VERI_BIT-1:0]  tut_veri, ram_veri, ram_q;
  logic [MASKE_BIT-1:0] ram_maske;

  // Ready only in BOSTA and never while reset is held.
  assign hazir      = (durum == BOSTA) && rst;
  assign kabul      = bus.istek_gecerli && hazir;
  assign gelen_hata = adres_hatali(bus.istek_adres, BELLEK_ADRES, BELLEK_KELIME);
  assign fark       = bus.istek_adres - BELLEK_ADRES;
  assign gelen_idx  = IDX_BIT'(fark >> 2);

  // With zero wait states the RAM is accessed on the acceptance edge itself,
  // so it must see the live request rather than the latched copy.
  assign ram_idx  = (durum == BOSTA) ? gelen_idx          : tut_idx;
  assign ram_yaz  = (durum == BOSTA) ? bus.istek_yaz      : tut_yaz;
  assign ram_veri = (durum == BOSTA) ? bus.istek_yaz_veri : tut_veri;

`ifdef BELLEK_BAYT_MASKE_EN
  logic [MASKE_BIT-1:0] tut_maske;
  assign ram_maske = (durum == BOSTA) ? bus.istek_maske : tut_maske;

  // Latch the strobes with the request so later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       tut_maske <= '0;
    else if (kabul) tut_maske <= bus.istek_maske;
  end
`else
  logic unused_maske;
  assign unused_maske = ^bus.istek_maske;
  assign ram_maske    = '1;
`endif

  // State, wait counter and the request snapshot taken at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum    <= BOSTA;
      sayac    <= 4'd0;
      tut_idx  <= '0;
      tut_yaz  <= 1'b0;
      tut_veri <= '0;
      tut_hata <= 1'b0;
    end else begin
      durum <= sonraki;
      if (kabul) begin
        tut_idx  <= gelen_idx;
        tut_yaz  <= bus.istek_yaz;
        tut_veri <= bus.istek_yaz_veri;
        tut_hata <= gelen_hata;
        sayac    <= YUKLE;
      end else if (durum == BEKLE && sayac != 4'd0) begin
        sayac <= sayac - 4'd1;
      end
    end
  end

  // Next state and the single RAM strobe on the edge that enters YANIT.
  always_comb begin
    sonraki = durum;
    ram_en  = 1'b0;
    case (durum)
      BOSTA: begin
        if (kabul) begin
          if (gelen_hata) begin
            sonraki = YANIT;
          end else if (BEKLEME == 0) begin
            sonraki = YANIT;
            ram_en  = 1'b1;
          end else begin
            sonraki = BEKLE;
          end
        end
      end
      BEKLE: begin
        if (sayac == 4'd0) begin
          sonraki = YANIT;
          ram_en  = 1'b1;
        end
      end
      YANIT: begin
        if (bus.yanit_hazir) sonraki = BOSTA;
      end
      default: sonraki = BOSTA;
    endcase
  end

  bellek_dizisi #(
    .KELIME  (BELLEK_KELIME),
    .IDX_BIT (IDX_BIT)
  ) u_dizi (
    .clk   (clk),
    .en    (ram_en),
    .yaz   (ram_yaz),
    .maske (ram_maske),
    .idx   (ram_idx),
    .veri  (ram_veri),
    .q     (ram_q)
  );

  // Response fields are zero outside YANIT; read data only for good reads.
  assign bus.istek_hazir   = hazir;
  assign bus.yanit_gecerli = (durum == YANIT);
  assign bus.yanit_hata    = (durum == YANIT) && tut_hata;
  assign bus.yanit_veri    = ((durum == YANIT) && !tut_yaz && !tut_hata) ? ram_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_bellek_denetleyici.sv
// ============================================================================
// Module  : tb_bellek_denetleyici
// Directed self-checking bench: one controller with BEKLEME=2 and one with
// BEKLEME=0, both on the default 1024-word window at 32'h8000_0000.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bellek_denetleyici;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_kontrol = 0;
  int   n_hata    = 0;

  always #5 clk = ~clk;

  bellek_if ifa ();
  bellek_if ifb ();

  bellek_denetleyici #(
    .BELLEK_ADRES  (32'h8000_0000),
    .BELLEK_KELIME (1024),
    .BEKLEME       (2)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  bellek_denetleyici #(
    .BELLEK_ADRES  (32'h8000_0000),
    .BELLEK_KELIME (1024),
    .BEKLEME       (0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic kontrol(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_kontrol++;
    assert (got === exp) else begin
      n_hata++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One transaction on dut_a, starting just after a rising edge. Returns the
  // response fields and the latency counted from the acceptance edge.
  task automatic islem_a(input logic yaz, input logic [31:0] adres, input logic [31:0] veri,
                         input logic [3:0] maske, input bit el_sikis,
                         output logic [31:0] rveri, output logic rhata, output int gecikme);
    int n = 0;
    ifa.istek_gecerli  = 1'b1;
    ifa.istek_yaz      = yaz;
    ifa.istek_adres    = adres;
    ifa.istek_yaz_veri = veri;
    ifa.istek_maske    = maske;
    while (ifa.istek_hazir !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    kontrol("a_kabul_hazir", 32'(ifa.istek_hazir), 32'd1);
    @(posedge clk); #1;
    ifa.istek_gecerli = 1'b0;
    gecikme = 1;
    while (ifa.yanit_gecerli !== 1'b1 && gecikme < 50) begin
      @(posedge clk); #1; gecikme++;
    end
    rveri = ifa.yanit_veri;
    rhata = ifa.yanit_hata;
    if (el_sikis) begin
      ifa.yanit_hazir = 1'b1;
      @(posedge clk); #1;
      ifa.yanit_hazir = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rv;
    logic        rh;
    int          g;
    int          n;
    logic [31:0] hatali [3];
    logic [31:0] ilk_veri;

    ifa.istek_gecerli = 1'b0; ifa.istek_yaz = 1'b0; ifa.istek_adres = '0;
    ifa.istek_yaz_veri = '0;  ifa.istek_maske = 4'h0; ifa.yanit_hazir = 1'b0;
    ifb.istek_gecerli = 1'b0; ifb.istek_yaz = 1'b0; ifb.istek_adres = '0;
    ifb.istek_yaz_veri = '0;  ifb.istek_maske = 4'hF; ifb.yanit_hazir = 1'b1;

    // Reset values while rst is low
    #2;
    kontrol("rst_istek_hazir",   32'(ifa.istek_hazir),   32'd0);
    kontrol("rst_yanit_gecerli", 32'(ifa.yanit_gecerli), 32'd0);
    kontrol("rst_yanit_veri",    ifa.yanit_veri,         32'd0);
    kontrol("rst_yanit_hata",    32'(ifa.yanit_hata),    32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    kontrol("rst_sonrasi_hazir", 32'(ifa.istek_hazir), 32'd1);

    // Known contents for words used later
    islem_a(1'b1, 32'h8000_0000, 32'h0, 4'hF, 1'b1, rv, rh, g);
    islem_a(1'b1, 32'h8000_0020, 32'h0, 4'hF, 1'b1, rv, rh, g);

    // Read after write, BEKLEME=2
    islem_a(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, rv, rh, g);
    kontrol("yaz_gecikme", 32'(g), 32'd3);
    kontrol("yaz_hata",    32'(rh), 32'd0);
    kontrol("yaz_veri",    rv, 32'd0);
    islem_a(1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b1, rv, rh, g);
    kontrol("oku_gecikme", 32'(g), 32'd3);
    kontrol("oku_veri",    rv, 32'hDEAD_BEEF);
    kontrol("oku_hata",    32'(rh), 32'd0);

    // Error cases: below window, past end, misaligned
    hatali[0] = 32'h7FFF_FFFC;
    hatali[1] = 32'h8000_1000;
    hatali[2] = 32'h8000_0002;
    for (int i = 0; i < 3; i++) begin
      islem_a(1'b1, hatali[i], 32'hFFFF_FFFF, 4'hF, 1'b1, rv, rh, g);
      kontrol("hata_gecikme", 32'(g), 32'd1);
      kontrol("hata_bayrak",  32'(rh), 32'd1);
      kontrol("hata_veri",    rv, 32'd0);
    end
    islem_a(1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b1, rv, rh, g);
    kontrol("hata_sonrasi_ram", rv, 32'h0);

    // Response backpressure with a competing request held valid
    islem_a(1'b1, 32'h8000_0040, 32'h1234_5678, 4'hF, 1'b1, rv, rh, g);
    islem_a(1'b0, 32'h8000_0040, 32'h0, 4'hF, 1'b0, rv, rh, g);
    kontrol("bp_ilk_veri", rv, 32'h1234_5678);
    ilk_veri = rv;
    ifa.istek_gecerli  = 1'b1;
    ifa.istek_yaz      = 1'b1;
    ifa.istek_adres    = 32'h8000_0040;
    ifa.istek_yaz_veri = 32'h0BAD_0BAD;
    ifa.istek_maske    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      kontrol("bp_veri_sabit",   ifa.yanit_veri,         ilk_veri);
      kontrol("bp_istek_hazir",  32'(ifa.istek_hazir),   32'd0);
      kontrol("bp_yanit_gecerli",32'(ifa.yanit_gecerli), 32'd1);
    end
    ifa.istek_gecerli = 1'b0;
    ifa.yanit_hazir   = 1'b1;
    @(posedge clk); #1;
    ifa.yanit_hazir = 1'b0;
    kontrol("bp_son_gecerli", 32'(ifa.yanit_gecerli), 32'd0);
    kontrol("bp_son_veri",    ifa.yanit_veri,         32'd0);
    kontrol("bp_son_hata",    32'(ifa.yanit_hata),    32'd0);
    kontrol("bp_son_hazir",   32'(ifa.istek_hazir),   32'd1);
    islem_a(1'b0, 32'h8000_0040, 32'h0, 4'hF, 1'b1, rv, rh, g);
    kontrol("bp_kabul_yok", rv, 32'h1234_5678);

    // Byte mask
    islem_a(1'b1, 32'h8000_0030, 32'h1111_1111, 4'hF, 1'b1, rv, rh, g);
    islem_a(1'b1, 32'h8000_0030, 32'hAABB_CCDD, 4'b0101, 1'b1, rv, rh, g);
    kontrol("maske_yaz_hata", 32'(rh), 32'd0);
    islem_a(1'b0, 32'h8000_0030, 32'h0, 4'hF, 1'b1, rv, rh, g);
`ifdef BELLEK_BAYT_MASKE_EN
    kontrol("maske_okuma", rv, 32'h11BB_11DD);
`else
    kontrol("maske_okuma", rv, 32'hAABB_CCDD);
`endif

    // Reset asserted during BEKLE drops the pending write
    ifa.istek_gecerli  = 1'b1;
    ifa.istek_yaz      = 1'b1;
    ifa.istek_adres    = 32'h8000_0020;
    ifa.istek_yaz_veri = 32'hCAFE_0000;
    ifa.istek_maske    = 4'hF;
    kontrol("rw_hazir_once", 32'(ifa.istek_hazir), 32'd1);
    @(posedge clk); #1;
    ifa.istek_gecerli = 1'b0;
    kontrol("rw_bekle_hazir",   32'(ifa.istek_hazir),   32'd0);
    kontrol("rw_bekle_gecerli", 32'(ifa.yanit_gecerli), 32'd0);
    rst = 1'b0;
    #1;
    kontrol("rw_rst_hazir",   32'(ifa.istek_hazir),   32'd0);
    kontrol("rw_rst_gecerli", 32'(ifa.yanit_gecerli), 32'd0);
    kontrol("rw_rst_veri",    ifa.yanit_veri,         32'd0);
    kontrol("rw_rst_hata",    32'(ifa.yanit_hata),    32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    kontrol("rw_birak_hazir", 32'(ifa.istek_hazir), 32'd1);
    islem_a(1'b0, 32'h8000_0020, 32'h0, 4'hF, 1'b1, rv, rh, g);
    kontrol("rw_okuma",   rv, 32'h0);
    kontrol("rw_gecikme", 32'(g), 32'd3);

    // BEKLEME=0: four writes then four reads, requests held valid back to back
    ifb.istek_gecerli = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifb.istek_yaz      = (i < 4);
      ifb.istek_adres    = 32'h8000_0100 + 32'(4 * (i % 4));
      ifb.istek_yaz_veri = 32'hA5A5_0000 + 32'(i);
      n = 0;
      while (ifb.istek_hazir !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      kontrol("b_hazir", 32'(ifb.istek_hazir), 32'd1);
      @(posedge clk); #1;
      if (i > 0) kontrol("b_aralik", 32'(n + 1), 32'd2);
      kontrol("b_gecikme", 32'(ifb.yanit_gecerli), 32'd1);
      kontrol("b_hata",    32'(ifb.yanit_hata),    32'd0);
      if (i >= 4) kontrol("b_veri", ifb.yanit_veri, 32'hA5A5_0000 + 32'(i - 4));
    end
    ifb.istek_gecerli = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bellek_denetleyici.md
Name: bellek_denetleyici

Overview:
- Main-memory controller between the multicycle core's memory port and a word-organised on-chip RAM.
- Accepts one read or write request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, checks address range and alignment, and returns data or an error over a valid/ready response channel.
- Replaces the direct zero-latency memory hookup, so the core's GETIR and load/store stages can stall on real memory timing.

Parameters:
- BELLEK_ADRES, 32'h8000_0000, byte base address of the RAM window.
- BELLEK_KELIME, 1024, RAM depth in 32-bit words; must be a power of two.
- BEKLEME, 2, wait cycles between request acceptance and response; 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset).
- istek_gecerli  input  1  request valid.
- istek_hazir  output  1  request ready.
- istek_adres  input  32  byte address.
- istek_yaz  input  1  1 = write, 0 = read.
- istek_yaz_veri  input  32  write data.
- istek_maske  input  4  byte write strobes; bit i covers data[8i+7:8i].
- yanit_gecerli  output  1  response valid.
- yanit_hazir  input  1  response ready.
- yanit_veri  output  32  read data; 0 for writes and errors.
- yanit_hata  output  1  access error flag, qualified by yanit_gecerli.

Behaviour:
- Reset (rst low, asynchronous):
  - state = BOSTA.
  - istek_hazir = 1 once rst is high; 0 while rst is low.
  - yanit_gecerli = 0, yanit_veri = 0, yanit_hata = 0.
  - Wait counter = 0.
  - RAM contents are not cleared.
- States: BOSTA, BEKLE, YANIT.
- BOSTA:
  - istek_hazir = 1.
  - On istek_gecerli & istek_hazir, latch address, direction, write data and mask.
  - Compute hata = (adres < BELLEK_ADRES) | (adres >= BELLEK_ADRES + 4*BELLEK_KELIME) | (adres[1:0] != 0).
  - If hata: go to YANIT next cycle with yanit_hata = 1. Error path has no wait states; the RAM is not touched.
  - Else if BEKLEME == 0: go to YANIT.
  - Else: go to BEKLE and load counter = BEKLEME - 1.
- BEKLE:
  - istek_hazir = 0.
  - Counter decrements each cycle; when counter == 0, go to YANIT.
- RAM access:
  - Performed exactly once, on the edge that enters YANIT.
  - Read data is registered into yanit_veri.
  - Write commits the enabled bytes.
- Word index = (adres - BELLEK_ADRES) >> 2; width is log2(BELLEK_KELIME).
- YANIT:
  - yanit_gecerli = 1; yanit_veri and yanit_hata are held stable until yanit_hazir.
  - On yanit_gecerli & yanit_hazir, go to BOSTA; yanit_gecerli = 0, yanit_veri = 0, yanit_hata = 0.
  - istek_hazir stays 0 while in YANIT: no request/response overlap.
- Latency: acceptance edge to yanit_gecerli high = BEKLEME + 1 cycles for valid addresses, 1 cycle for errors.
- Request inputs are sampled only at acceptance; changes during BEKLE/YANIT have no effect.
- Reset asserted in BEKLE: the pending write is dropped (no RAM change). Reset asserted in YANIT: a write has already committed; the response is lost.
- Address arithmetic is 32-bit unsigned. The upper-bound comparison is done in 33 bits so a window ending at 2^32 does not wrap.

Optional Feature:
- BELLEK_BAYT_MASKE_EN
  - Defined: writes honour istek_maske per byte; mask 4'b0000 is a legal no-op write returning yanit_hata = 0.
  - Undefined: istek_maske is ignored and every write updates all 4 bytes. The port still exists, unconnected internally.

Decomposition:
- Shared package bellek_paket:
  - BELLEK_ADRES default.
  - VERI_BIT = 32, ADRES_BIT = 32.
  - State encoding localparams BOSTA = 2'd0, BEKLE = 2'd1, YANIT = 2'd2.
  - Mask width 4.
- One sub-module, bellek_dizisi:
  - Single-port synchronous RAM, BELLEK_KELIME x 32.
  - Per-byte write enables, registered read.
  - Instantiated once; the controller owns all sequencing.

Test Plan:
- Read after write, BEKLEME=2: write 32'hDEAD_BEEF to 32'h8000_0010 with mask 4'hF, then read the same address. Each response arrives 3 cycles after acceptance; the read returns 32'hDEAD_BEEF with yanit_hata = 0.
- Error cases: request to 32'h7FFF_FFFC, to 32'h8000_1000 (depth 1024), and to misaligned 32'h8000_0002. Each gets yanit_gecerli 1 cycle after acceptance with yanit_hata = 1 and yanit_veri = 0; a follow-up read of 32'h8000_0000 is unchanged.
- Response backpressure: hold yanit_hazir = 0 for 5 cycles during a read of a word preloaded with 32'h1234_5678. yanit_veri stays stable, istek_hazir stays 0, and a new istek_gecerli is not accepted until the handshake completes.
- Byte mask (BELLEK_BAYT_MASKE_EN defined): word holds 32'h1111_1111; write 32'hAABB_CCDD with mask 4'b0101. Readback = 32'h11BB_11DD. With the macro undefined, readback = 32'hAABB_CCDD.
- Reset mid-write: accept a write of 32'hCAFE_0000 to 32'h8000_0020 (old value 32'h0), pull rst low during BEKLE, then release. Outputs read 0, istek_hazir = 1 after release, and a read returns 32'h0.
- BEKLEME=0 back-to-back: four reads with yanit_hazir tied high. Each response appears 1 cycle after acceptance, with acceptances every 2 cycles.
